// File: rtl/mult_pkg.sv
// mult_pkg: shared width default and FSM encoding for the Booth multiplier
package mult_pkg;
  localparam int MULT_WIDTH = 32;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth add/sub followed by arithmetic right shift of {acc,mult,qm1}
module booth_step import mult_pkg::*; #(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic signed [WIDTH:0]   acc,
  input  logic        [WIDTH-1:0] mult,
  input  logic                    qm1,
  input  logic signed [WIDTH:0]   mcand,
  output logic signed [WIDTH:0]   acc_nx,
  output logic        [WIDTH-1:0] mult_nx,
  output logic                    qm1_nx
);
  logic signed [WIDTH:0] sum;
  // recode {mult[0],qm1} into add/sub/keep, then shift the whole triple right by one
  always_comb begin
    sum = ({mult[0], qm1} == 2'b01) ? acc + mcand : ({mult[0], qm1} == 2'b10) ? acc - mcand : acc;
    acc_nx = {sum[WIDTH], sum[WIDTH:1]};
    mult_nx = {sum[0], mult[WIDTH-1:1]};
    qm1_nx = mult[0];
  end
endmodule

// File: rtl/mult_booth.sv
// mult_booth: sequential radix-2 Booth signed multiplier, one step per RUN cycle
module mult_booth import mult_pkg::*; #(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clock,
  input  logic               clr_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               result_valid,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);
  state_t state, state_nx;
  logic signed [WIDTH:0] acc, mcand, acc_s;
  logic [WIDTH-1:0] mult, mult_s;
  logic qm1, qm1_s;
  logic [5:0] cnt;
  logic last;
  logic [2*WIDTH-1:0] prod_nx;
  assign last = cnt == 6'(WIDTH-1);
  assign prod_nx = {acc_s[WIDTH-1:0], mult_s};
  assign busy = state != IDLE;
  assign result_valid = state == DONE;
  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc(acc), .mult(mult), .qm1(qm1), .mcand(mcand),
    .acc_nx(acc_s), .mult_nx(mult_s), .qm1_nx(qm1_s)
  );
  // state register
  always_ff @(posedge clock)
    state <= !clr_n ? IDLE : state_nx;
  // next state: accept start only in IDLE, leave RUN after the last step, DONE lasts one cycle
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && start) ? RUN : (state == RUN && last) ? DONE : (state == DONE) ? IDLE : state;
  end
  // datapath: load operands on accepted start, step during RUN, capture product on the last step
  always_ff @(posedge clock) begin
    if (!clr_n) begin
      acc <= '0;
      mult <= '0;
      qm1 <= 1'b0;
      mcand <= '0;
      cnt <= '0;
      product <= '0;
      ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      acc <= '0;
      mult <= op_b;
      qm1 <= 1'b0;
      mcand <= {op_a[WIDTH-1], op_a};
      cnt <= '0;
    end else if (state == RUN) begin
      acc <= acc_s;
      mult <= mult_s;
      qm1 <= qm1_s;
      cnt <= cnt + 6'd1;
      if (last) begin
        product <= prod_nx;
        ovf <= !(&prod_nx[2*WIDTH-1:WIDTH-1] || ~|prod_nx[2*WIDTH-1:WIDTH-1]);
      end
    end
  end
endmodule

// File: tb/tb_mult_booth.sv
// tb_mult_booth: randomized scoreboard bench for mult_booth against plain signed arithmetic
module tb_mult_booth;
  localparam int W = 32;
  typedef struct {
    logic [2*W-1:0] p;
    logic o;
    int c;
  } exp_t;
  logic clk, clr_n, start, busy, result_valid, ovf;
  logic [W-1:0] op_a, op_b;
  logic [2*W-1:0] product;
  int total, bad, cyc;
  bit chk_idle;
  exp_t q[$];
  mult_booth #(.WIDTH(W)) dut (
    .clock(clk), .clr_n(clr_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .result_valid(result_valid), .product(product), .ovf(ovf)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, logic [2*W-1:0] got, logic [2*W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic go(logic [W-1:0] a, logic [W-1:0] b);
    int k = 0;
    exp_t e;
    longint pl;
    logic signed [2*W-1:0] p;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", {63'd0, busy}, 64'd0);
    p = $signed(a) * $signed(b);
    pl = p;
    e.p = p;
    e.o = (pl > 64'sd2147483647) || (pl < -64'sd2147483648);
    e.c = cyc;
    q.push_back(e);
    start = 1'b1;
    op_a = a;
    op_b = b;
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (chk_idle) begin
      chk_idle = 1'b0;
      chk("busy_after_done", {63'd0, busy}, 64'd0);
    end
    if (result_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", {63'd0, result_valid}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("product", product, e.p);
        chk("ovf", {63'd0, ovf}, {63'd0, e.o});
        chk("latency", 64'(cyc - e.c), 64'(W + 1));
        chk_idle = 1'b1;
      end
    end
  end
  initial begin
    logic [W-1:0] edge_v[6];
    edge_v = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'hFFFF_0000};
    total = 0;
    bad = 0;
    cyc = 0;
    chk_idle = 1'b0;
    clr_n = 1'b0;
    start = 1'b1;
    op_a = 32'd5;
    op_b = 32'd7;
    repeat (2) @(negedge clk);
    start = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valid", {63'd0, result_valid}, 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    clr_n = 1'b1;
    @(negedge clk);
    chk("rst_start_ignored", {63'd0, busy}, 64'd0);
    go(32'd3, 32'd5);
    go(-32'sd7, 32'd6);
    go(32'h8000_0000, 32'h8000_0000);
    go(32'h7FFF_FFFF, 32'd2);
    go(32'h8000_0000, 32'h7FFF_FFFF);
    go(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    go(32'h0, 32'h8000_0000);
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      a = (i % 3 == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
      b = (i % 4 == 1) ? edge_v[$urandom_range(0, 5)] : $urandom;
      if (i % 5 == 2) b = $urandom_range(0, 15);
      go(a, b);
    end
    drain();
    go(32'd4, 32'd4);
    repeat (10) @(negedge clk);
    start = 1'b1;
    op_a = 32'd9;
    op_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    chk("hold_product", product, 64'd16);
    chk("hold_busy", {63'd0, busy}, 64'd0);
    go($urandom, $urandom);
    for (int i = 0; i < 100 && !result_valid; i++) @(negedge clk);
    start = 1'b1;
    op_a = 32'd11;
    op_b = 32'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("done_start_busy", {63'd0, busy}, 64'd0);
    chk("done_start_drain", 64'(q.size()), 64'd0);
    go(32'd1234, 32'd5678);
    repeat (19) @(negedge clk);
    chk("run_busy", {63'd0, busy}, 64'd1);
    clr_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    q.delete();
    chk("clr_busy", {63'd0, busy}, 64'd0);
    chk("clr_product", product, 64'd0);
    chk("clr_ovf", {63'd0, ovf}, 64'd0);
    clr_n = 1'b1;
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("clr_no_restart", {63'd0, busy}, 64'd0);
    go(32'hFFFF_FFF9, 32'd6);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_booth.md
MULT_BOOTH -- requirements
Module: mult_booth

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; product width is 2*WIDTH.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port clr_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port op_a  input  WIDTH  signed multiplicand; sampled with start.
REQ-006 SHALL have port op_b  input  WIDTH  signed multiplier; sampled with start.
REQ-007 SHALL have port busy  output  1  high in RUN and DONE.
REQ-008 SHALL have port result_valid  output  1  one-cycle pulse; drives the enable of the downstream 64-bit product register.
REQ-009 SHALL have port product  output  2*WIDTH  signed product; stable from the result_valid cycle until the next accepted start.
REQ-010 SHALL have port ovf  output  1  high when the product is not representable in WIDTH signed bits; valid with product.

Function
REQ-011 SHALL use radix-2 Booth multiplication with a WIDTH+1-bit signed accumulator, a WIDTH-bit multiplier shift register, a q_minus1 bit and a 6-bit iteration counter.
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-013 SHALL make these transitions: IDLE->RUN on start=1; RUN->DONE when the counter reaches WIDTH-1; DONE->IDLE unconditionally after one cycle.
REQ-014 On start in IDLE SHALL load accumulator=0, multiplier=op_b, q_minus1=0, multiplicand=sign-extended op_a, and counter=0.
REQ-015 SHALL perform one step per RUN cycle on {mult[0],q_minus1}: 01 -> acc+=M; 10 -> acc-=M; 00/11 -> no change; then arithmetic right shift of {acc,mult,q_minus1} by 1 and counter+1.
REQ-016 SHALL assert result_valid exactly in the DONE cycle, which is WIDTH+1 cycles after the start edge (33 for WIDTH=32).
REQ-017 SHALL register product as {acc[WIDTH-1:0],mult} when entering DONE and hold it until the next accepted start.
REQ-018 SHALL set ovf=1 iff product[2*WIDTH-1:WIDTH-1] is not all-equal.
REQ-019 SHALL ignore start while in RUN or DONE; operands and the result SHALL be unaffected.
REQ-020 SHALL treat start and DONE in the same cycle as ignored; the new start SHALL be accepted only when the FSM is in IDLE.
REQ-021 SHALL produce an exact result for all operand pairs, including op_a=op_b=-2^(WIDTH-1).
REQ-022 SHALL keep busy, result_valid and ovf free of combinational paths from start/op_a/op_b; all three SHALL be decoded from registered state.

Reset
REQ-023 SHALL, when clr_n=0 at a rising clock edge, force state=IDLE, product=0, ovf=0, result_valid=0, busy=0, counter=0 and accumulator=0.
REQ-024 SHALL abandon an in-flight RUN on reset with no result_valid pulse; start asserted during the reset cycle SHALL be ignored.
REQ-025 SHALL have no asynchronous reset path.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the WIDTH default in shared package mult_pkg.
REQ-027 SHALL implement the add/sub/arithmetic-shift datapath as combinational sub-module booth_step.
REQ-028 SHALL keep sequential state in mult_booth only; booth_step SHALL contain no storage.

Verification
REQ-029 Scenario: op_a=3, op_b=5, start pulse -> result_valid high exactly 33 cycles later; product=15, ovf=0.
REQ-030 Scenario: op_a=-7, op_b=6 -> product=0xFFFF_FFFF_FFFF_FFD6, ovf=0.
REQ-031 Scenario: op_a=op_b=0x8000_0000 -> product=0x4000_0000_0000_0000, ovf=1.
REQ-032 Scenario: op_a=0x7FFF_FFFF, op_b=2 -> product=0x0000_0000_FFFF_FFFE, ovf=1.
REQ-033 Scenario: start with op_a=9, op_b=9 pulsed during cycle 10 of a RUN of 4*4 -> single result_valid; product=16; busy low the cycle after DONE.
REQ-034 Scenario: clr_n=0 at RUN cycle 20 -> next cycle busy=0, product=0, ovf=0; no result_valid pulse for 40 cycles.
